// File: rtl/matrak_pkg.sv
// Shared definitions for the memory arbiter.
//   - Port index constants for the three requesters.
//   - Owner encoding for the read-return register (2 bits, IDLE = 3).
//   - Rank order used by the grant logic, highest rank first.
package matrak_pkg;

    localparam int NUM_PORTS = 3;

    localparam int PORT_IF   = 0;  // instruction fetch
    localparam int PORT_DATA = 1;  // CPU load/store
    localparam int PORT_LDR  = 2;  // UART bootloader / debug loader

    localparam logic [1:0] OWNER_IDLE = 2'd3;

    // Data beats loader beats ifetch: a stalled load/store costs the most,
    // and the loader only runs while the CPU is quiesced.
    localparam int RANK_ORDER [NUM_PORTS] = '{PORT_DATA, PORT_LDR, PORT_IF};

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// starve_counter: counts consecutive cycles a requester was denied.
//   clk_i      system clock
//   rst_i      asynchronous active-low reset
//   req_i      requester is asking this cycle
//   gnt_i      requester is granted this cycle
//   cnt_o      current count (saturates at LIMIT)
//   starved_o  count has reached LIMIT; always 0 when LIMIT == 0
module starve_counter
    import matrak_pkg::*;
#(
    parameter int LIMIT = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic             gnt_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             starved_o
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (gnt_i || !req_i) begin
            cnt_q <= '0;
        end else if (cnt_q != LIM) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o     = cnt_q;
    assign starved_o = (LIMIT != 0) && (cnt_q == LIM);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between
// ifetch (port 0), data (port 1) and loader (port 2).
//   clk_i, rst_i          clock, asynchronous active-low reset
//   req_i/wen_i/stb_i     per-port request, write enable, byte strobes
//   addr_i/wdata_i        per-port address and write data, 32 bits per port
//   gnt_o                 one-hot grant; command issued this cycle
//   rvalid_o/rdata_o      one-hot read valid one cycle after a read grant,
//                         with the memory read data broadcast to all ports
//   mem_*                 command to the memory; mem_rdata_i returns data
//                         the cycle after a read
// Handshake: a requester holds req and its command fields stable until it
// sees gnt in the same cycle; the command is accepted on that clock edge and
// the requester may drop req or present a new command the following cycle.
module mem_arbiter
    import matrak_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  req_i,
    input  logic [2:0]  wen_i,
    input  logic [11:0] stb_i,
    input  logic [95:0] addr_i,
    input  logic [95:0] wdata_i,
    output logic [2:0]  gnt_o,
    output logic [2:0]  rvalid_o,
    output logic [31:0] rdata_o,
    output logic        mem_en_o,
    output logic        mem_wen_o,
    output logic [3:0]  mem_stb_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    logic [NUM_PORTS-1:0][CNT_W-1:0] cnt;
    logic [NUM_PORTS-1:0]            starved;
    logic [1:0]                      gnt_idx;
    logic [1:0]                      owner_q;
    logic [1:0]                      owner_d;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt
        starve_counter #(
            .LIMIT (STARVE_LIMIT),
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .req_i     (req_i[p]),
            .gnt_i     (gnt_o[p]),
            .cnt_o     (cnt[p]),
            .starved_o (starved[p])
        );
    end

    // Walk the ranks from highest down. When any requester is starved, only
    // starved requesters are eligible, so two starved ports still resolve by
    // rank and the loser keeps its saturated count for the next cycle.
    always_comb begin
        logic any_starved;
        logic found;
        gnt_o       = '0;
        found       = 1'b0;
        any_starved = |(req_i & starved);
        for (int r = 0; r < NUM_PORTS; r++) begin
            if (!found && req_i[RANK_ORDER[r]] &&
                (!any_starved || starved[RANK_ORDER[r]])) begin
                gnt_o[RANK_ORDER[r]] = 1'b1;
                found                = 1'b1;
            end
        end
        if (!rst_i) begin
            gnt_o = '0;
        end
    end

    // Command mux: all mem_* fields are zero when nothing is granted.
    always_comb begin
        mem_wen_o   = 1'b0;
        mem_stb_o   = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        gnt_idx     = OWNER_IDLE;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt_o[p]) begin
                mem_wen_o   = wen_i[p];
                mem_stb_o   = stb_i[4*p +: 4];
                mem_addr_o  = addr_i[32*p +: 32];
                mem_wdata_o = wdata_i[32*p +: 32];
                gnt_idx     = 2'(p);
            end
        end
    end

    assign mem_en_o = |gnt_o;

    // Owner tags the read that the memory answers next cycle; writes and
    // idle cycles leave it IDLE so no rvalid is raised.
    assign owner_d = (mem_en_o && !mem_wen_o) ? gnt_idx : OWNER_IDLE;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            owner_q <= OWNER_IDLE;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        rvalid_o = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rvalid_o[p] = (owner_q == 2'(p));
        end
    end

    assign rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk_i;
    logic        rst_i;
    logic [2:0]  req_i;
    logic [2:0]  wen_i;
    logic [11:0] stb_i;
    logic [95:0] addr_i;
    logic [95:0] wdata_i;
    logic [2:0]  gnt_o;
    logic [2:0]  rvalid_o;
    logic [31:0] rdata_o;
    logic        mem_en_o;
    logic        mem_wen_o;
    logic [3:0]  mem_stb_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(
        .STARVE_LIMIT (4),
        .CNT_W        (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .wen_i       (wen_i),
        .stb_i       (stb_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .mem_en_o    (mem_en_o),
        .mem_wen_o   (mem_wen_o),
        .mem_stb_o   (mem_stb_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model ----------------
    // Synchronous single-port memory; contents are (re)loaded while reset is low.
    logic [31:0] mem [0:63];

    always @(posedge clk_i) begin
        if (!rst_i) begin
            mem[0] <= 32'hCAFE_0000;
            mem[1] <= 32'hCAFE_0004;
            mem[2] <= 32'hCAFE_0008;
            mem[4] <= 32'h0010_0093;
            mem[8] <= 32'h1122_3344;
        end else if (mem_en_o) begin
            if (mem_wen_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_stb_o[b]) mem[mem_addr_o[7:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
                end
            end else begin
                mem_rdata_i <= mem[mem_addr_o[7:2]];
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_port(input int p, input logic wen, input logic [3:0] stb,
                            input logic [31:0] addr, input logic [31:0] wdata);
        req_i[p]             = 1'b1;
        wen_i[p]             = wen;
        stb_i[4*p +: 4]      = stb;
        addr_i[32*p +: 32]   = addr;
        wdata_i[32*p +: 32]  = wdata;
    endtask

    task automatic clear_all();
        req_i   = '0;
        wen_i   = '0;
        stb_i   = '0;
        addr_i  = '0;
        wdata_i = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_all();
        rst_i = 1'b0;
        req_i = 3'b111;
        repeat (3) tick();
        n_checks++;
        if (gnt_o !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b want 000", gnt_o); end
        n_checks++;
        if (mem_en_o !== 1'b0 || mem_wen_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_mem_en: got en=%b wen=%b want 0 0", mem_en_o, mem_wen_o);
        end
        n_checks++;
        if (rvalid_o !== 3'b000) begin n_fail++; $display("FAIL reset_rvalid: got %b want 000", rvalid_o); end
        n_checks++;
        if (dut.cnt[0] !== 4'd0 || dut.cnt[1] !== 4'd0 || dut.cnt[2] !== 4'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d %0d %0d want 0 0 0", dut.cnt[0], dut.cnt[1], dut.cnt[2]);
        end
        clear_all();
        rst_i = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        clear_all();
        set_port(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
        #1;
        n_checks++;
        if (gnt_o !== 3'b001) begin n_fail++; $display("FAIL single_gnt: got %b want 001", gnt_o); end
        n_checks++;
        if (mem_en_o !== 1'b1 || mem_addr_o !== 32'h10) begin
            n_fail++; $display("FAIL single_cmd: got en=%b addr=%h want 1 00000010", mem_en_o, mem_addr_o);
        end
        tick();
        clear_all();
        #1;
        n_checks++;
        if (rvalid_o !== 3'b001) begin n_fail++; $display("FAIL single_rvalid: got %b want 001", rvalid_o); end
        n_checks++;
        if (rdata_o !== 32'h0010_0093) begin n_fail++; $display("FAIL single_rdata: got %h want 00100093", rdata_o); end
        n_checks++;
        if (mem_en_o !== 1'b0 || mem_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL idle_cmd: got en=%b addr=%h want 0 00000000", mem_en_o, mem_addr_o);
        end
        tick();
        n_checks++;
        if (rvalid_o !== 3'b000) begin n_fail++; $display("FAIL single_rvalid_off: got %b want 000", rvalid_o); end
    endtask

    task automatic test_contention();
        clear_all();
        set_port(0, 1'b0, 4'hF, 32'h0, 32'h0);
        set_port(1, 1'b0, 4'hF, 32'h4, 32'h0);
        set_port(2, 1'b0, 4'hF, 32'h8, 32'h0);
        #1;
        n_checks++;
        if (gnt_o !== 3'b010) begin n_fail++; $display("FAIL cont_gnt1: got %b want 010", gnt_o); end
        tick();
        req_i[1] = 1'b0;
        #1;
        n_checks++;
        if (gnt_o !== 3'b100) begin n_fail++; $display("FAIL cont_gnt2: got %b want 100", gnt_o); end
        n_checks++;
        if (rvalid_o !== 3'b010 || rdata_o !== 32'hCAFE_0004) begin
            n_fail++; $display("FAIL cont_rv1: got %b %h want 010 cafe0004", rvalid_o, rdata_o);
        end
        tick();
        req_i[2] = 1'b0;
        #1;
        n_checks++;
        if (gnt_o !== 3'b001 || mem_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL cont_gnt3: got %b addr %h want 001 00000000", gnt_o, mem_addr_o);
        end
        n_checks++;
        if (rvalid_o !== 3'b100 || rdata_o !== 32'hCAFE_0008) begin
            n_fail++; $display("FAIL cont_rv2: got %b %h want 100 cafe0008", rvalid_o, rdata_o);
        end
        tick();
        clear_all();
        #1;
        n_checks++;
        if (rvalid_o !== 3'b001 || rdata_o !== 32'hCAFE_0000) begin
            n_fail++; $display("FAIL cont_rv3: got %b %h want 001 cafe0000", rvalid_o, rdata_o);
        end
        tick();
    endtask

    task automatic test_starvation();
        clear_all();
        set_port(0, 1'b0, 4'hF, 32'h0, 32'h0);
        set_port(1, 1'b0, 4'hF, 32'h4, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            #1;
            n_checks++;
            if (gnt_o !== 3'b010 || dut.cnt[0] !== 4'(k - 1)) begin
                n_fail++; $display("FAIL starve_cycle%0d: got gnt %b cnt %0d want 010 %0d", k, gnt_o, dut.cnt[0], k - 1);
            end
            tick();
        end
        #1;
        n_checks++;
        if (gnt_o !== 3'b001 || dut.cnt[0] !== 4'd4) begin
            n_fail++; $display("FAIL starve_promote: got gnt %b cnt %0d want 001 4", gnt_o, dut.cnt[0]);
        end
        tick();
        #1;
        n_checks++;
        if (gnt_o !== 3'b010) begin n_fail++; $display("FAIL starve_resume: got %b want 010", gnt_o); end
        n_checks++;
        if (dut.cnt[0] !== 4'd0 || dut.cnt[1] !== 4'd1) begin
            n_fail++; $display("FAIL starve_cnt_after: got %0d %0d want 0 1", dut.cnt[0], dut.cnt[1]);
        end
        n_checks++;
        if (rvalid_o !== 3'b001 || rdata_o !== 32'hCAFE_0000) begin
            n_fail++; $display("FAIL starve_rv: got %b %h want 001 cafe0000", rvalid_o, rdata_o);
        end
        clear_all();
        tick();
        tick();
    endtask

    task automatic test_write_strobe();
        clear_all();
        set_port(1, 1'b1, 4'b0100, 32'h20, 32'h00AB_0000);
        #1;
        n_checks++;
        if (gnt_o !== 3'b010 || mem_wen_o !== 1'b1 || mem_stb_o !== 4'b0100) begin
            n_fail++; $display("FAIL write_cmd: got gnt %b wen %b stb %b want 010 1 0100", gnt_o, mem_wen_o, mem_stb_o);
        end
        n_checks++;
        if (mem_addr_o !== 32'h20 || mem_wdata_o !== 32'h00AB_0000) begin
            n_fail++; $display("FAIL write_data: got %h %h want 00000020 00ab0000", mem_addr_o, mem_wdata_o);
        end
        tick();
        clear_all();
        set_port(1, 1'b0, 4'hF, 32'h20, 32'h0);
        #1;
        n_checks++;
        if (rvalid_o !== 3'b000) begin n_fail++; $display("FAIL write_no_rvalid: got %b want 000", rvalid_o); end
        tick();
        clear_all();
        #1;
        n_checks++;
        if (rvalid_o !== 3'b010 || rdata_o !== 32'h11AB_3344) begin
            n_fail++; $display("FAIL write_readback: got %b %h want 010 11ab3344", rvalid_o, rdata_o);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        clear_all();
        set_port(0, 1'b0, 4'hF, 32'h0, 32'h0);
        set_port(2, 1'b0, 4'hF, 32'h8, 32'h0);
        #1;
        n_checks++;
        if (gnt_o !== 3'b100) begin n_fail++; $display("FAIL rstmid_gnt1: got %b want 100", gnt_o); end
        tick();
        #1;
        n_checks++;
        if (gnt_o !== 3'b100 || dut.cnt[0] !== 4'd1 || rvalid_o !== 3'b100) begin
            n_fail++; $display("FAIL rstmid_gnt2: got gnt %b cnt %0d rv %b want 100 1 100", gnt_o, dut.cnt[0], rvalid_o);
        end
        #1;
        rst_i = 1'b0;
        #1;
        n_checks++;
        if (gnt_o !== 3'b000 || mem_en_o !== 1'b0 || rvalid_o !== 3'b000) begin
            n_fail++; $display("FAIL rstmid_async: got gnt %b en %b rv %b want 000 0 000", gnt_o, mem_en_o, rvalid_o);
        end
        clear_all();
        tick();
        n_checks++;
        if (rvalid_o !== 3'b000) begin n_fail++; $display("FAIL rstmid_dropped: got %b want 000", rvalid_o); end
        rst_i = 1'b1;
        tick();
        n_checks++;
        if (rvalid_o !== 3'b000 || dut.cnt[0] !== 4'd0 || dut.cnt[1] !== 4'd0 || dut.cnt[2] !== 4'd0) begin
            n_fail++; $display("FAIL rstmid_release: got rv %b cnt %0d %0d %0d want 000 0 0 0",
                               rvalid_o, dut.cnt[0], dut.cnt[1], dut.cnt[2]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_data [3];
        exp_data[0] = 32'hCAFE_0000;
        exp_data[1] = 32'hCAFE_0004;
        exp_data[2] = 32'hCAFE_0008;
        clear_all();
        for (int k = 0; k < 4; k++) begin
            if (k < 3) set_port(0, 1'b0, 4'hF, 32'(4 * k), 32'h0);
            else clear_all();
            #1;
            if (k < 3) begin
                n_checks++;
                if (gnt_o !== 3'b001) begin n_fail++; $display("FAIL pipe_gnt%0d: got %b want 001", k, gnt_o); end
            end
            if (k > 0) begin
                n_checks++;
                if (rvalid_o !== 3'b001 || rdata_o !== exp_data[k-1]) begin
                    n_fail++; $display("FAIL pipe_rv%0d: got %b %h want 001 %h", k, rvalid_o, rdata_o, exp_data[k-1]);
                end
            end
            tick();
        end
        n_checks++;
        if (rvalid_o !== 3'b000) begin n_fail++; $display("FAIL pipe_end: got %b want 000", rvalid_o); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        clear_all();
        rst_i = 1'b0;
        test_reset();
        test_single_read();
        test_contention();
        test_starvation();
        test_write_strobe();
        test_reset_mid_read();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port synchronous program/data memory between three requesters:
  - port 0: instruction fetch
  - port 1: CPU load/store
  - port 2: UART bootloader/debug loader
- Replaces the ad-hoc address mux and stall logic in top with a req/gnt handshake.
- Default priority with a starvation guard; returns read data with a one-cycle tag so each requester sees only its own responses.

Parameters:
- STARVE_LIMIT, 8: consecutive denied cycles before a requester is promoted to top priority; 0 disables the guard.
- CNT_W, 4: starvation counter width; must hold STARVE_LIMIT.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-low reset
- req_i  in  3  per-port request, index 0 = ifetch, 1 = data, 2 = loader
- wen_i  in  3  per-port write enable (1 = write, 0 = read)
- stb_i  in  12  per-port byte strobes; port n uses [4n+3:4n]
- addr_i  in  96  per-port byte address; port n uses [32n+31:32n]
- wdata_i  in  96  per-port write data, same packing as addr_i
- gnt_o  out  3  one-hot grant; command accepted this cycle
- rvalid_o  out  3  one-hot read-data-valid, one cycle after a read grant
- rdata_o  out  32  read data broadcast to all ports; qualified by rvalid_o
- mem_en_o  out  1  memory access this cycle
- mem_wen_o  out  1  memory write
- mem_stb_o  out  4  memory byte strobes
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data, valid the cycle after a read

Behaviour:
- Reset (rst_i = 0, asynchronous):
  - all starvation counters = 0; owner register = IDLE; rvalid_o = 0.
  - gnt_o = 0, mem_en_o = 0 and mem_wen_o = 0 while rst_i is low.
  - A read in flight when reset asserts is dropped; no rvalid is produced.
- Handshake:
  - Requester holds req, wen, stb, addr and wdata stable until it sees gnt.
  - Grant is combinational from the current req_i and registered counter state, so a command is issued in the same cycle it is granted.
  - The requester may drop req or present a new command the cycle after gnt.
  - Back-to-back grants are allowed every cycle, to the same or different ports.
- Arbitration per cycle (exactly one grant when any req_i is set):
  - If any requesting port has counter == STARVE_LIMIT (and STARVE_LIMIT != 0), grant the starved port with the highest rank.
  - Otherwise grant the requesting port with the highest rank.
  - Fixed rank order: data (1) > loader (2) > ifetch (0).
- Memory command: mem_* mirrors the granted port's fields. mem_en_o = |gnt_o. mem_wen_o = granted wen. No grant → mem_en_o = 0, mem_wen_o = 0, other mem_* = 0.
- Starvation counter, per port, each cycle:
  - req & !gnt → increment, saturating at STARVE_LIMIT;
  - gnt or !req → clear to 0.
- Read return:
  - A granted read loads owner = port index; a write or no grant loads IDLE.
  - Next cycle: rvalid_o[owner] = 1 (all zero if IDLE); rdata_o = mem_rdata_i, passed through combinationally.
  - A read grant on the cycle of an earlier read's rvalid is legal; pipelined throughput is one read per cycle.
- Writes complete at grant and produce no rvalid.
- The CPU stall in top becomes (req_i[n] & !gnt_o[n]) | read-awaiting-rvalid, computed outside this block.
- Simultaneous starvation of two ports: resolved by the rank order; the loser keeps its saturated counter and wins next cycle unless the data port is also starved.

Decomposition:
- Shared package (matrak_pkg):
  - port index constants PORT_IF = 0, PORT_DATA = 1, PORT_LDR = 2, and the OWNER_IDLE encoding (2-bit owner, IDLE = 3).
  - rank-order constant.
- One natural sub-module: starve_counter (one saturating counter with clear), instantiated three times.
- Grant logic, mux and owner register stay in mem_arbiter.

Test Plan:
- Single read: req_i = 3'b001, addr 0x0000_0010, memory holds 0x0010_0093 → gnt_o = 001 that cycle, mem_addr_o = 0x10; next cycle rvalid_o = 001, rdata_o = 0x0010_0093.
- Contention: req_i = 3'b111 held, all reads → grants 010 on the first cycle. The data port drops after gnt, then loader wins (100) and drops; ifetch is granted third. rvalid_o follows each grant by one cycle with the correct one-hot bit.
- Starvation: STARVE_LIMIT = 4; data port requests continuously and ifetch requests continuously → ifetch gnt on cycle 5. The data port is denied that cycle, then resumes winning; ifetch counter reads 0 after its grant.
- Write plus byte strobes: port 1, wen = 1, stb = 4'b0100, addr 0x20, wdata 0x00AB_0000 → mem_wen_o = 1, mem_stb_o = 0100, no rvalid; a later read of 0x20 returns byte 2 = 0xAB.
- Reset mid-read: grant a read on port 2, assert rst_i low before the next edge → rvalid_o stays 000; all counters are 0 after release.
- Pipelined reads: port 0 reads 0x0, 0x4, 0x8 on consecutive cycles → rvalid_o[0] high for 3 consecutive cycles with data in address order.
